// File: rtl/mem_port_arbiter_if.sv
// Handshake and memory-side bundle for mem_port_arbiter.
// slave: the arbiter. master: the requesters/memory side (testbench or CPU top).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ldr_req;
  logic              ldr_wr;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_ack;
  logic [DATA_W-1:0] ldr_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  ldr_req, ldr_wr, ldr_addr, ldr_wdata,
    output ldr_ack, ldr_rdata,
    output mem_addr, mem_wr, mem_din,
    input  mem_dout
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output ldr_req, ldr_wr, ldr_addr, ldr_wdata,
    input  ldr_ack, ldr_rdata,
    input  mem_addr, mem_wr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares single-port Memoria between the CPU path and the
// loader/debug port. Serialises accesses, sequences the fixed read latency
// MEM_LAT, returns registered rdata plus a one-cycle ack to the granted side.
// Optional feature macro: MEM_ARB_RR_EN (round-robin on ties; default is
// fixed priority with cpu winning).
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {GNT_CPU, GNT_LDR} gnt_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  gnt_t              gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              ldr_ack_q, ldr_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
  logic              pick_ldr;

`ifdef MEM_ARB_RR_EN
  gnt_t              last_gnt_q, last_gnt_d;
`endif

  // Arbitration decision among requests currently present.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    pick_ldr = bus.ldr_req && (!bus.cpu_req || (last_gnt_q == GNT_CPU));
`else
    pick_ldr = bus.ldr_req && !bus.cpu_req;
`endif
  end

  // Next-state logic: grant in IDLE, count latency in ACCESS, ack in RESP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_gnt_d  = last_gnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req || bus.ldr_req) begin
          state_d = ACCESS;
          cnt_d   = '0;
          if (pick_ldr) begin
            gnt_d   = GNT_LDR;
            addr_d  = bus.ldr_addr;
            wr_d    = bus.ldr_wr;
            wdata_d = bus.ldr_wdata;
          end else begin
            gnt_d   = GNT_CPU;
            addr_d  = bus.cpu_addr;
            wr_d    = bus.cpu_wr;
            wdata_d = bus.cpu_wdata;
          end
`ifdef MEM_ARB_RR_EN
          last_gnt_d = gnt_d;
`endif
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          // Ack is raised here so it is registered and visible in RESP.
          if (gnt_q == GNT_CPU) begin
            cpu_ack_d = 1'b1;
            if (!wr_q) cpu_rdata_d = bus.mem_dout;
          end else begin
            ldr_ack_d = 1'b1;
            if (!wr_q) ldr_rdata_d = bus.mem_dout;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_q       <= GNT_CPU;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ldr_ack_q   <= ldr_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Last granted requester; reset to LDR so the first tie goes to cpu.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_gnt_q <= GNT_LDR;
    else        last_gnt_q <= last_gnt_d;
  end
`endif

  // Memory drive from latched copies; write strobe only in first ACCESS cycle.
  always_comb begin
    bus.mem_addr  = addr_q;
    bus.mem_din   = wdata_q;
    bus.mem_wr    = (state_q == ACCESS) && (cnt_q == '0) && wr_q;
    bus.cpu_ack   = cpu_ack_q;
    bus.cpu_rdata = cpu_rdata_q;
    bus.ldr_ack   = ldr_ack_q;
    bus.ldr_rdata = ldr_rdata_q;
    busy          = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a MEM_LAT=2 memory
// model (one registered read stage). Honours MEM_ARB_RR_EN for tie ordering.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LAT = 2;
`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clock;
  logic reset;
  logic busy;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  // Memory model: write on the edge after mem_wr, dout one edge after address.
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] dout_q;
  always @(posedge clock) begin
    if (bus.mem_wr) mem[bus.mem_addr[7:0]] <= bus.mem_din;
    dout_q <= mem[bus.mem_addr[7:0]];
  end
  assign bus.mem_dout = dout_q;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  int n;
  bit got_cpu, got_ldr;
  int wr_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Wait (bounded) for any ack; n = edge index (0-based) at which it appeared.
  task automatic wait_ack(output int nn, output bit c, output bit l, output int w);
    nn = -1; c = 1'b0; l = 1'b0; w = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.mem_wr === 1'b1) w++;
      if (bus.cpu_ack === 1'b1 || bus.ldr_ack === 1'b1) begin
        nn = i; c = bus.cpu_ack; l = bus.ldr_ack;
        break;
      end
    end
  endtask

  // Drop requests, step into IDLE, confirm ack was a single-cycle pulse.
  task automatic finish_xfer(input string tag);
    bus.cpu_req = 1'b0;
    bus.ldr_req = 1'b0;
    tick();
    check({tag, "_ack_drop"}, {62'd0, bus.cpu_ack, bus.ldr_ack}, 64'd0);
    check({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic cpu_go(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_req = 1'b1; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic ldr_go(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ldr_req = 1'b1; bus.ldr_wr = wr; bus.ldr_addr = a; bus.ldr_wdata = d;
  endtask

  initial begin
    #200000;
    $error("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit exp_cpu;
    reset = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ldr_req = 1'b0; bus.ldr_wr = 1'b0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
    tick(); tick();

    // Reset state
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_memwr", {63'd0, bus.mem_wr}, 64'd0);
    check("rst_acks", {62'd0, bus.cpu_ack, bus.ldr_ack}, 64'd0);
    check("rst_maddr", 64'(bus.mem_addr), 64'd0);
    check("rst_crdata", 64'(bus.cpu_rdata), 64'd0);
    reset = 1'b1;
    tick();

    // Loader writes 0x10 <= DEADBEEF
    ldr_go(1'b1, 32'h10, 32'hDEADBEEF);
    wait_ack(n, got_cpu, got_ldr, wr_cyc);
    check("w10_lat", 64'(n), 64'd2);
    check("w10_who", {62'd0, got_cpu, got_ldr}, 64'd1);
    check("w10_wrcyc", 64'(wr_cyc), 64'd1);
    finish_xfer("w10");
    check("w10_mem", 64'(mem[8'h10]), 64'hDEADBEEF);

    // Loader writes 0x20 <= 12345678; ldr_rdata untouched by a write
    ldr_go(1'b1, 32'h20, 32'h12345678);
    wait_ack(n, got_cpu, got_ldr, wr_cyc);
    check("w20_lat", 64'(n), 64'd2);
    check("w20_who", {62'd0, got_cpu, got_ldr}, 64'd1);
    check("w20_wrcyc", 64'(wr_cyc), 64'd1);
    check("w20_rdata_keep", 64'(bus.ldr_rdata), 64'd0);
    finish_xfer("w20");

    // CPU single read 0x10
    cpu_go(1'b0, 32'h10, '0);
    tick();
    check("r10_busy", {63'd0, busy}, 64'd1);
    check("r10_nowr", {63'd0, bus.mem_wr}, 64'd0);
    wait_ack(n, got_cpu, got_ldr, wr_cyc);
    check("r10_lat", 64'(n), 64'd1);
    check("r10_who", {62'd0, got_cpu, got_ldr}, 64'd2);
    check("r10_data", 64'(bus.cpu_rdata), 64'hDEADBEEF);
    finish_xfer("r10");

    // Loader read back 0x20
    ldr_go(1'b0, 32'h20, '0);
    wait_ack(n, got_cpu, got_ldr, wr_cyc);
    check("r20_lat", 64'(n), 64'd2);
    check("r20_who", {62'd0, got_cpu, got_ldr}, 64'd1);
    check("r20_data", 64'(bus.ldr_rdata), 64'h12345678);
    check("r20_cpu_keep", 64'(bus.cpu_rdata), 64'hDEADBEEF);
    finish_xfer("r20");

    // Ties with both held: fixed -> cpu,cpu,cpu; round robin -> cpu,ldr,cpu
    cpu_go(1'b0, 32'h10, '0);
    ldr_go(1'b0, 32'h20, '0);
    for (int k = 0; k < 3; k++) begin
      exp_cpu = RR_EN ? ((k % 2) == 0) : 1'b1;
      wait_ack(n, got_cpu, got_ldr, wr_cyc);
      check($sformatf("tie%0d_lat", k), 64'(n), (k == 0) ? 64'd2 : 64'd3);
      check($sformatf("tie%0d_who", k), {62'd0, got_cpu, got_ldr}, {62'd0, exp_cpu, !exp_cpu});
      if (exp_cpu) check($sformatf("tie%0d_data", k), 64'(bus.cpu_rdata), 64'hDEADBEEF);
      else         check($sformatf("tie%0d_data", k), 64'(bus.ldr_rdata), 64'h12345678);
    end
    bus.cpu_req = 1'b0;
    wait_ack(n, got_cpu, got_ldr, wr_cyc);
    check("tie_ldr_lat", 64'(n), 64'd3);
    check("tie_ldr_who", {62'd0, got_cpu, got_ldr}, 64'd1);
    finish_xfer("tie");

    // Inputs changed and req dropped mid-access: latched copy completes
    cpu_go(1'b0, 32'h10, '0);
    tick();
    bus.cpu_req = 1'b0; bus.cpu_wr = 1'b1; bus.cpu_addr = 32'h20; bus.cpu_wdata = 32'h0BAD0BAD;
    #1;
    check("mid_maddr", 64'(bus.mem_addr), 64'h10);
    check("mid_nowr", {63'd0, bus.mem_wr}, 64'd0);
    wait_ack(n, got_cpu, got_ldr, wr_cyc);
    check("mid_lat", 64'(n), 64'd1);
    check("mid_who", {62'd0, got_cpu, got_ldr}, 64'd2);
    check("mid_data", 64'(bus.cpu_rdata), 64'hDEADBEEF);
    check("mid_wrcyc", 64'(wr_cyc), 64'd0);
    finish_xfer("mid");
    check("mid_mem20", 64'(mem[8'h20]), 64'h12345678);

    // Reset during a write's first ACCESS cycle
    cpu_go(1'b1, 32'h30, 32'hAAAA5555);
    tick();
    check("rmid_wr_on", {63'd0, bus.mem_wr}, 64'd1);
    check("rmid_busy_on", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    check("rmid_wr_off", {63'd0, bus.mem_wr}, 64'd0);
    check("rmid_busy_off", {63'd0, busy}, 64'd0);
    check("rmid_rdata_clr", 64'(bus.cpu_rdata), 64'd0);
    bus.cpu_req = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.cpu_ack === 1'b1 || bus.ldr_ack === 1'b1) n++;
    end
    check("rmid_noack", 64'(n), 64'd0);
    check("rmid_mem30", {63'd0, (mem[8'h30] === 32'hAAAA5555)}, 64'd0);
    reset = 1'b1;
    tick();
    cpu_go(1'b0, 32'h10, '0);
    wait_ack(n, got_cpu, got_ldr, wr_cyc);
    check("post_lat", 64'(n), 64'd2);
    check("post_who", {62'd0, got_cpu, got_ldr}, 64'd2);
    check("post_data", 64'(bus.cpu_rdata), 64'hDEADBEEF);
    finish_xfer("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
